// File: rtl/calc_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// calc_cmd_scheduler
//
// Sits between the keypad decoder and the calculator core. Key codes are
// buffered in a small FIFO and handed to the core one at a time. A command is
// issued only while the core reports ready (2'b10). The core must then go busy
// (2'b01 or 2'b11) and come back to ready before the next command is issued.
// A core error (2'b00) seen while a command is in flight traps the block in
// ERROR until reset. A command that stalls for TIMEOUT cycles is abandoned.
//
// Parameters:
//   DEPTH    FIFO depth in entries (power of two, >= 2)
//   TIMEOUT  cycles allowed in ISSUE/WAIT_READY before abandoning (>= 1)
//
// Ports:
//   clock             system clock, rising edge
//   reset             asynchronous, active-high reset
//   key_valid_i       key code present this cycle
//   key_code_i[3:0]   keypad code, passed through unmodified
//   key_ready_o       FIFO can accept a code (combinational)
//   core_status_i     00 error, 01 busy, 10 ready, 11 treated as busy
//   core_cmd_o[3:0]   command to the core, held from issue to next issue
//   core_cmd_valid_o  high while a command is offered (ISSUE)
//   fill_o            FIFO occupancy
//   busy_o            state not IDLE or FIFO non-empty (combinational)
//   error_o           sticky core-error flag
//   timeout_o         sticky command-abandoned flag
// -----------------------------------------------------------------------------
module calc_cmd_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     key_valid_i,
  input  logic [3:0]               key_code_i,
  output logic                     key_ready_o,
  input  logic [1:0]               core_status_i,
  output logic [3:0]               core_cmd_o,
  output logic                     core_cmd_valid_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     busy_o,
  output logic                     error_o,
  output logic                     timeout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  // The counter only ever holds 0..TIMEOUT-1.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [FW-1:0] FILL_ZERO = {FW{1'b0}};
  localparam logic [FW-1:0] FILL_ONE  = FW'(1);
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_ISSUE      = 2'b01,
    ST_WAIT_READY = 2'b10,
    ST_ERROR      = 2'b11
  } state_t;

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [FW-1:0] fill_q;
  state_t        state_q;
  logic [3:0]    cmd_q;
  logic          cmd_valid_q;
  logic          error_q;
  logic          timeout_q;
  logic [CW-1:0] tmo_cnt_q;

  logic ready_s;
  logic push_s;
  logic pop_s;
  logic flush_s;
  logic in_flight_s;
  logic status_err_s;
  logic status_rdy_s;
  logic status_busy_s;
  logic tmo_hit_s;

  // Handshake decode: push/pop/flush qualifiers and the two combinational outputs.
  always_comb begin
    in_flight_s   = (state_q == ST_ISSUE) || (state_q == ST_WAIT_READY);
    status_err_s  = (core_status_i == 2'b00);
    status_rdy_s  = (core_status_i == 2'b10);
    // 2'b01 and 2'b11 both mean busy.
    status_busy_s = core_status_i[0];
    tmo_hit_s     = (tmo_cnt_q == CNT_LAST);
    ready_s       = (fill_q != FILL_FULL) && (state_q != ST_ERROR);
    push_s        = key_valid_i && ready_s;
    // Gated on fill_q, so a code pushed into an empty FIFO pops one edge later.
    pop_s         = (state_q == ST_IDLE) && (fill_q != FILL_ZERO) && status_rdy_s;
    // Entering ERROR discards everything queued.
    flush_s       = in_flight_s && status_err_s;
  end

  assign key_ready_o      = ready_s;
  assign busy_o           = (state_q != ST_IDLE) || (fill_q != FILL_ZERO);
  assign fill_o           = fill_q;
  assign core_cmd_o       = cmd_q;
  assign core_cmd_valid_o = cmd_valid_q;
  assign error_o          = error_q;
  assign timeout_o        = timeout_q;

  // FIFO storage: accepted codes are written at the tail.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= key_code_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      fill_q   <= FILL_ZERO;
    end else if (flush_s) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      fill_q   <= FILL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   fill_q <= fill_q + FILL_ONE;
        2'b01:   fill_q <= fill_q - FILL_ONE;
        default: fill_q <= fill_q;
      endcase
    end
  end

  // Issue FSM with registered command, valid, sticky flags and stall counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 4'b0000;
      cmd_valid_q <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
      tmo_cnt_q   <= CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A core error reported while nothing is in flight is ignored here.
          if (pop_s) begin
            cmd_q       <= mem_q[rd_ptr_q];
            cmd_valid_q <= 1'b1;
            tmo_cnt_q   <= CNT_ZERO;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Error outranks timeout; timeout outranks the busy acknowledge.
          if (status_err_s) begin
            cmd_valid_q <= 1'b0;
            error_q     <= 1'b1;
            state_q     <= ST_ERROR;
          end else if (tmo_hit_s) begin
            cmd_valid_q <= 1'b0;
            timeout_q   <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (status_busy_s) begin
            cmd_valid_q <= 1'b0;
            tmo_cnt_q   <= tmo_cnt_q + CNT_ONE;
            state_q     <= ST_WAIT_READY;
          end else begin
            tmo_cnt_q   <= tmo_cnt_q + CNT_ONE;
          end
        end
        ST_WAIT_READY: begin
          // A core that returns to ready on the last allowed cycle completes normally.
          if (status_err_s) begin
            error_q   <= 1'b1;
            state_q   <= ST_ERROR;
          end else if (status_rdy_s) begin
            state_q   <= ST_IDLE;
          end else if (tmo_hit_s) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_ONE;
          end
        end
        ST_ERROR: begin
          cmd_valid_q <= 1'b0;
        end
        default: begin
          cmd_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_cmd_scheduler.sv
module tb_calc_cmd_scheduler;

  localparam int M_RESP   = 0;  // ready, goes busy for one cycle per command
  localparam int M_BUSY   = 1;  // held busy
  localparam int M_STUCK  = 2;  // held ready, never acknowledges
  localparam int M_MANUAL = 3;  // status driven by hand

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid_i = 1'b0;
  logic [3:0] key_code_i = 4'd0;
  logic       key_ready_o;
  logic [1:0] core_status_i = 2'b10;
  logic [3:0] core_cmd_o;
  logic       core_cmd_valid_o;
  logic [2:0] fill_o;
  logic       busy_o;
  logic       error_o;
  logic       timeout_o;

  int         errors = 0;
  int         checks = 0;
  int         core_mode = M_RESP;
  logic       prev_valid = 1'b0;
  logic [3:0] exp_q [$];

  typedef struct {
    logic [3:0] code;
    logic       acc;
    logic [2:0] fill;
  } vec_t;

  vec_t basic_v [4];
  vec_t ovf_v [6];

  calc_cmd_scheduler #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .key_valid_i      (key_valid_i),
    .key_code_i       (key_code_i),
    .key_ready_o      (key_ready_o),
    .core_status_i    (core_status_i),
    .core_cmd_o       (core_cmd_o),
    .core_cmd_valid_o (core_cmd_valid_o),
    .fill_o           (fill_o),
    .busy_o           (busy_o),
    .error_o          (error_o),
    .timeout_o        (timeout_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // One clock: sample just after the edge, score new issues, update core model.
  task automatic step();
    logic [3:0] e;
    @(posedge clock);
    #1;
    if (core_cmd_valid_o && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got cmd %0h want no issue", core_cmd_o);
      end else begin
        e = exp_q.pop_front();
        chk("issue_cmd", core_cmd_o, e);
      end
    end
    prev_valid = core_cmd_valid_o;
    case (core_mode)
      M_RESP:  core_status_i = core_cmd_valid_o ? 2'b01 : 2'b10;
      M_BUSY:  core_status_i = 2'b01;
      M_STUCK: core_status_i = 2'b10;
      default: core_status_i = core_status_i;
    endcase
  endtask

  task automatic push(input logic [3:0] c, input logic acc);
    key_valid_i = 1'b1;
    key_code_i  = c;
    chk("key_ready_at_push", key_ready_o, acc);
    if (acc) exp_q.push_back(c);
    step();
    key_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy_o || exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk({nm, "_drained"}, (!busy_o && exp_q.size() == 0), 1);
    chk({nm, "_fill0"}, fill_o, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    key_valid_i = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    prev_valid = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    basic_v[0] = '{4'd5,  1'b1, 3'd1};
    basic_v[1] = '{4'd10, 1'b1, 3'd1};
    basic_v[2] = '{4'd3,  1'b1, 3'd2};
    basic_v[3] = '{4'd14, 1'b1, 3'd3};
    ovf_v[0] = '{4'd1, 1'b1, 3'd1};
    ovf_v[1] = '{4'd2, 1'b1, 3'd2};
    ovf_v[2] = '{4'd3, 1'b1, 3'd3};
    ovf_v[3] = '{4'd4, 1'b1, 3'd4};
    ovf_v[4] = '{4'd5, 1'b0, 3'd4};
    ovf_v[5] = '{4'd6, 1'b0, 3'd4};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", core_cmd_valid_o, 0);
    chk("rst_cmd", core_cmd_o, 0);
    chk("rst_fill", fill_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_timeout", timeout_o, 0);
    reset = 1'b0;
    #1;
    chk("rst_key_ready", key_ready_o, 1);

    // Basic sequencing with a one-cycle-busy core
    core_mode = M_RESP;
    core_status_i = 2'b10;
    for (int i = 0; i < 4; i++) begin
      push(basic_v[i].code, basic_v[i].acc);
      chk("basic_fill", fill_o, basic_v[i].fill);
      if (i == 0) chk("basic_no_same_cycle_pop", core_cmd_valid_o, 0);
    end
    wait_idle("basic");

    // Overflow with the core held busy
    core_mode = M_BUSY;
    core_status_i = 2'b01;
    for (int i = 0; i < 6; i++) begin
      push(ovf_v[i].code, ovf_v[i].acc);
      chk("ovf_fill", fill_o, ovf_v[i].fill);
    end
    chk("ovf_key_ready_full", key_ready_o, 0);
    core_mode = M_RESP;
    core_status_i = 2'b10;
    wait_idle("ovf");

    // Simultaneous push/pop at fill=1 across pointer wraps
    push(4'd15, 1'b1);
    for (int i = 0; i < 10; i++) begin
      push(4'(i + 3), 1'b1);
      chk("wrap_fill_pushpop", fill_o, 1);
      step();
      chk("wrap_fill_wait", fill_o, 1);
      step();
      chk("wrap_fill_idle", fill_o, 1);
    end
    wait_idle("wrap");

    // Timeout: core stays ready and never acknowledges
    core_mode = M_STUCK;
    core_status_i = 2'b10;
    push(4'd7, 1'b1);
    push(4'd8, 1'b1);  // this edge enters ISSUE with code 7
    for (int k = 1; k < 8; k++) begin
      step();
      chk("tmo_not_yet", timeout_o, 0);
      chk("tmo_valid_held", core_cmd_valid_o, 1);
      chk("tmo_cmd_held", core_cmd_o, 7);
    end
    step();
    chk("tmo_flag", timeout_o, 1);
    chk("tmo_valid_drop", core_cmd_valid_o, 0);
    step();
    chk("tmo_next_issued", core_cmd_valid_o, 1);
    core_mode = M_RESP;
    core_status_i = 2'b01;
    wait_idle("tmo");
    chk("tmo_sticky", timeout_o, 1);

    // Error trap; status 00 in IDLE is ignored
    core_mode = M_BUSY;
    core_status_i = 2'b01;
    push(4'd11, 1'b1);
    push(4'd12, 1'b1);
    push(4'd13, 1'b1);
    core_mode = M_MANUAL;
    core_status_i = 2'b00;
    step();
    step();
    chk("err_idle_ignored", error_o, 0);
    chk("err_idle_fill", fill_o, 3);
    core_status_i = 2'b10;
    step();
    chk("err_issue_fill", fill_o, 2);
    core_status_i = 2'b01;
    step();
    chk("err_wait_noerr", error_o, 0);
    core_status_i = 2'b00;
    step();
    exp_q.delete();
    chk("err_flag", error_o, 1);
    chk("err_fill", fill_o, 0);
    chk("err_key_ready", key_ready_o, 0);
    chk("err_valid", core_cmd_valid_o, 0);
    chk("err_busy", busy_o, 1);
    core_status_i = 2'b10;
    push(4'd2, 1'b0);
    push(4'd3, 1'b0);
    step();
    chk("err_push_ignored", fill_o, 0);
    chk("err_stays", error_o, 1);
    pulse_reset();
    chk("err_reset_error", error_o, 0);
    chk("err_reset_timeout", timeout_o, 0);
    chk("err_reset_key_ready", key_ready_o, 1);
    chk("err_reset_busy", busy_o, 0);

    // Reset mid-command while in ISSUE with fill=3
    core_mode = M_BUSY;
    core_status_i = 2'b01;
    for (int i = 0; i < 4; i++) push(4'(i + 4), 1'b1);
    core_mode = M_MANUAL;
    core_status_i = 2'b10;
    step();
    chk("mid_fill3", fill_o, 3);
    chk("mid_in_issue", core_cmd_valid_o, 1);
    reset = 1'b1;
    #1;
    chk("mid_valid", core_cmd_valid_o, 0);
    chk("mid_cmd", core_cmd_o, 0);
    chk("mid_fill", fill_o, 0);
    chk("mid_busy", busy_o, 0);
    pulse_reset();
    chk("mid_key_ready", key_ready_o, 1);
    core_mode = M_RESP;
    core_status_i = 2'b10;
    push(4'd9, 1'b1);
    wait_idle("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
